ahci_dma_wr_pack: RTL and testbench

- Write-direction counterpart of the AHCI DMA read realign FIFO.
- Accepts 32-bit word-aligned data from the device side and packs it into 64-bit QWORD-aligned AXI write beats with per-byte strobes.
- Handles arbitrary 16-bit word start offset (woffs) and arbitrary word count.
- Single clock domain (hclk); sits between the SATA receive datapath and the AXI HP write channel.

---
 rtl/ahci_dma_wr_pack.sv | 222 ++++++++++++++++++++++
 tb/tb_ahci_dma_wr_pack.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahci_dma_wr_pack.sv
// ahci_dma_wr_pack
//   Packs 32-bit device-side dwords into 64-bit QWORD-aligned AXI write beats
//   with per-byte strobes. The first 16-bit word lands in lane woffs; the
//   following words fill successive lanes and wrap into the next QWORD.
//   Completed QWORDs go through a small FIFO whose head drives dout.
//
// Ports
//   hclk, hrst_n        clock, async active-low reset
//   wcnt, woffs, start  transfer setup (0-based word count, first-word lane)
//   din, din_vld, din_re    dword input handshake (low half = earlier word)
//   dout, dout_wstb, dout_vld, dout_re   FIFO head / pop
//   busy, done          transfer in progress / one-cycle completion pulse
//   abort               only with AHCI_DMA_WR_PACK_ABORT_EN defined
//
// Optional feature macro: AHCI_DMA_WR_PACK_ABORT_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | accepting dwords into the accumulator
// TAIL  | queue the partially filled last QWORD, if any
// DRAIN | wait for the FIFO to empty, then pulse done
module ahci_dma_wr_pack #(
  parameter int WCNT_BITS    = 21,
  parameter int ADDRESS_BITS = 3
) (
  input  logic                 hclk,
  input  logic                 hrst_n,
  input  logic [WCNT_BITS-1:0] wcnt,
  input  logic [1:0]           woffs,
  input  logic                 start,
  input  logic [31:0]          din,
  input  logic                 din_vld,
  output logic                 din_re,
  output logic [63:0]          dout,
  output logic [7:0]           dout_wstb,
  output logic                 dout_vld,
  input  logic                 dout_re,
  output logic                 busy,
  output logic                 done
`ifdef AHCI_DMA_WR_PACK_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int DEPTH = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS+1:0] FILL_MAX = (ADDRESS_BITS+2)'(DEPTH - 2);
  localparam logic [ADDRESS_BITS:0]   PTR_ONE  = {{ADDRESS_BITS{1'b0}}, 1'b1};
  localparam logic [WCNT_BITS-1:0]    DW_ONE   = {{(WCNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [WCNT_BITS-1:0] dw_left;
  logic                 last_single;
  logic [1:0]           pos;
  logic [63:0]          acc_data;
  logic [3:0]           acc_lanes;
  logic                 push_vld;
  logic [63:0]          push_data;
  logic [7:0]           push_stb;
  logic [ADDRESS_BITS:0] wr_ptr, rd_ptr, fill;
  logic [ADDRESS_BITS+1:0] fill_pend;
  logic [63:0]          mem_data [DEPTH];
  logic [7:0]           mem_stb  [DEPTH];

  logic        abort_hit;
  logic        fifo_full, fifo_wr, pop, accept, two_words, qw_done;
  logic        ld, tail_push, drain_fin;
  logic [2:0]  pos1;
  logic [127:0] ext_data;
  logic [7:0]  ext_lanes;

`ifdef AHCI_DMA_WR_PACK_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [7:0] lane_stb(input logic [3:0] lanes);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) s[2*k +: 2] = {2{lanes[k]}};
    return s;
  endfunction

  // FIFO bookkeeping; the extra pointer bit distinguishes full from empty.
  assign fill      = wr_ptr - rd_ptr;
  assign fifo_full = (wr_ptr[ADDRESS_BITS-1:0] == rd_ptr[ADDRESS_BITS-1:0]) &&
                     (wr_ptr[ADDRESS_BITS] != rd_ptr[ADDRESS_BITS]);
  assign fifo_wr   = push_vld && !fifo_full;
  assign dout_vld  = (wr_ptr != rd_ptr);
  assign pop       = dout_vld && dout_re;
  assign dout      = dout_vld ? mem_data[rd_ptr[ADDRESS_BITS-1:0]] : '0;
  assign dout_wstb = dout_vld ? mem_stb[rd_ptr[ADDRESS_BITS-1:0]]  : '0;

  // A QWORD written next cycle still needs a slot, so count it as occupied.
  assign fill_pend = {1'b0, fill} + {{(ADDRESS_BITS+1){1'b0}}, push_vld};
  assign din_re    = (state_q == S_RUN) && (dw_left != '0) && (fill_pend <= FILL_MAX);
  assign accept    = din_vld && din_re;
  assign busy      = (state_q != S_IDLE);

  // With an odd word count the last dword carries only its low word.
  assign two_words = !(last_single && (dw_left == DW_ONE));

  // Place the dword into an 8-lane window: lanes 0-3 are the QWORD being
  // built, lanes 4-7 catch a word that wraps into the next QWORD.
  always_comb begin
    pos1      = {1'b0, pos} + 3'd1;
    ext_data  = {64'd0, acc_data} | ({112'd0, din[15:0]} << {pos, 4'b0000});
    ext_lanes = {4'd0, acc_lanes} | (8'd1 << pos);
    if (two_words) begin
      ext_data  = ext_data | ({112'd0, din[31:16]} << {pos1, 4'b0000});
      ext_lanes = ext_lanes | (8'd1 << pos1);
    end
  end
  // Lanes fill in order, so lane 3 occupied means the QWORD is complete.
  assign qw_done = ext_lanes[3];

  always_comb begin
    state_d   = state_q;
    ld        = 1'b0;
    tail_push = 1'b0;
    drain_fin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ld      = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && (dw_left == DW_ONE)) state_d = S_TAIL;
      end
      S_TAIL: begin
        tail_push = (acc_lanes != 4'd0);
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        if (!push_vld && ((fill == '0) || ((fill == PTR_ONE) && pop))) begin
          drain_fin = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d   = S_IDLE;
      ld        = 1'b0;
      tail_push = 1'b0;
      drain_fin = 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q     <= S_IDLE;
      done        <= 1'b0;
      dw_left     <= '0;
      last_single <= 1'b0;
      pos         <= 2'd0;
      acc_data    <= '0;
      acc_lanes   <= '0;
      push_vld    <= 1'b0;
      push_data   <= '0;
      push_stb    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q <= state_d;
      done    <= drain_fin || abort_hit;
      if (abort_hit) begin
        dw_left   <= '0;
        acc_data  <= '0;
        acc_lanes <= '0;
        push_vld  <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        push_vld <= 1'b0;
        if (ld) begin
          dw_left     <= (wcnt >> 1) + DW_ONE;
          last_single <= !wcnt[0];
          pos         <= woffs;
          acc_data    <= '0;
          acc_lanes   <= '0;
        end
        if (accept) begin
          dw_left <= dw_left - DW_ONE;
          pos     <= pos + (two_words ? 2'd2 : 2'd1);
          if (qw_done) begin
            push_vld  <= 1'b1;
            push_data <= ext_data[63:0];
            push_stb  <= lane_stb(ext_lanes[3:0]);
            acc_data  <= ext_data[127:64];
            acc_lanes <= ext_lanes[7:4];
          end else begin
            acc_data  <= ext_data[63:0];
            acc_lanes <= ext_lanes[3:0];
          end
        end
        if (tail_push) begin
          push_vld  <= 1'b1;
          push_data <= acc_data;
          push_stb  <= lane_stb(acc_lanes);
          acc_data  <= '0;
          acc_lanes <= '0;
        end
        if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr[ADDRESS_BITS-1:0]] <= push_data;
      mem_stb[wr_ptr[ADDRESS_BITS-1:0]]  <= push_stb;
    end
  end

endmodule

// File: tb/tb_ahci_dma_wr_pack.sv
`timescale 1ns/1ps
module tb_ahci_dma_wr_pack;
  localparam int WB = 21;
  localparam int AB = 3;
  localparam int DEPTH = 1 << AB;

  logic          hclk = 1'b0;
  logic          hrst_n = 1'b0;
  logic [WB-1:0] wcnt_in = '0;
  logic [1:0]    woffs_in = 2'd0;
  logic          start = 1'b0;
  logic [31:0]   din = '0;
  logic          din_vld = 1'b0;
  logic          din_re;
  logic [63:0]   dout;
  logic [7:0]    dout_wstb;
  logic          dout_vld;
  logic          dout_re = 1'b0;
  logic          busy;
  logic          done;
`ifdef AHCI_DMA_WR_PACK_ABORT_EN
  logic          abort = 1'b0;
`endif

  ahci_dma_wr_pack #(.WCNT_BITS(WB), .ADDRESS_BITS(AB)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .wcnt(wcnt_in), .woffs(woffs_in),
    .start(start), .din(din), .din_vld(din_vld), .din_re(din_re),
    .dout(dout), .dout_wstb(dout_wstb), .dout_vld(dout_vld),
    .dout_re(dout_re), .busy(busy), .done(done)
`ifdef AHCI_DMA_WR_PACK_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] dw_q[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_stb[$];
  bit  mon_en = 0;
  bit  m_active = 0, m_last = 0, pop_prev = 0, prev_hold = 0;
  int  m_woffs, m_wcnt, m_D, m_Q, m_N, m_k, m_kp, m_pops, d_cyc;
  logic [63:0] prev_dout;
  logic [7:0]  prev_stb;

  // Expected QWORD stream straight from lane arithmetic.
  task automatic model_fill(input int woffs, input int wcnt);
    int n, q;
    logic [31:0] t;
    logic [63:0] d;
    logic [7:0]  s;
    n = wcnt + 1;
    q = ((woffs + wcnt) >> 2) + 1;
    exp_data.delete();
    exp_stb.delete();
    for (int qi = 0; qi < q; qi++) begin
      d = '0; s = '0;
      for (int lane = 0; lane < 4; lane++) begin
        int g;
        g = qi * 4 + lane - woffs;
        if (g >= 0 && g < n) begin
          t = dw_q[g / 2];
          d[lane*16 +: 16] = (g % 2 == 1) ? t[31:16] : t[15:0];
          s[lane*2 +: 2] = 2'b11;
        end
      end
      exp_data.push_back(d);
      exp_stb.push_back(s);
    end
    m_woffs = woffs; m_wcnt = wcnt; m_N = n; m_Q = q; m_D = (wcnt >> 1) + 1;
    m_k = 0; m_kp = 0; m_pops = 0; m_last = 0; d_cyc = 0;
    pop_prev = 0; prev_hold = 0; m_active = 0;
  endtask

  function automatic int compl(input int k);
    return (m_woffs + 2 * k) / 4;
  endfunction

  always @(negedge hclk) begin
    if (mon_en) begin
      bit exp_done, exp_busy, exp_re, exp_vld, pop;
      int vis;
      if (m_last) d_cyc++;
      exp_done = m_active && pop_prev && (m_pops == m_Q);
      if (m_kp < m_D) vis = compl(m_kp);
      else if (d_cyc == 2) vis = (m_woffs + m_N) / 4;
      else vis = m_Q;
      exp_vld  = m_active && (vis - m_pops > 0);
      exp_busy = m_active && !exp_done;
      exp_re   = exp_busy && (m_k < m_D) && (compl(m_k) - m_pops <= DEPTH - 2);
      check("done", done, exp_done);
      check("busy", busy, exp_busy);
      check("dout_vld", dout_vld, exp_vld);
      check("din_re", din_re, exp_re);
      if (prev_hold) begin
        check("hold_data", dout, prev_dout);
        check("hold_stb", dout_wstb, prev_stb);
      end
      pop = dout_vld && dout_re;
      if (pop) begin
        if (exp_data.size() == 0) check("extra_pop", 1, 0);
        else begin
          check("dout", dout, exp_data.pop_front());
          check("dout_wstb", dout_wstb, exp_stb.pop_front());
        end
        m_pops++;
      end
      pop_prev  = pop;
      prev_hold = dout_vld && !dout_re;
      prev_dout = dout;
      prev_stb  = dout_wstb;
      m_kp = m_k;
      if (din_vld && din_re) begin
        m_k++;
        if (m_k == m_D) begin m_last = 1; d_cyc = 0; end
      end
      if (exp_done) m_active = 0;
      else if (start && !m_active) m_active = 1;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_re(input int re_mode);
    if (re_mode == 0) dout_re = 1'($urandom_range(0, 1));
    else if (re_mode == 1) dout_re = 1'b1;
    else dout_re = 1'b0;
  endtask

  task automatic load_dwords(input int wcnt);
    dw_q.delete();
    for (int i = 0; i < (wcnt >> 1) + 1; i++) dw_q.push_back($urandom);
  endtask

  task automatic run_xfer(input int woffs, input int wcnt, input int re_mode,
                          input int vld_pct, input int bp_cycles, input int bp_k,
                          input bit junk);
    int d, idx, cyc;
    bit got;
    d = (wcnt >> 1) + 1;
    model_fill(woffs, wcnt);
    mon_en = 1;
    @(posedge hclk); #1;
    start = 1'b1; wcnt_in = wcnt[WB-1:0]; woffs_in = woffs[1:0];
    drive_re(bp_cycles > 0 ? 2 : re_mode);
    @(posedge hclk); #1;
    start = 1'b0; wcnt_in = WB'($urandom); woffs_in = 2'($urandom);
    idx = 0; cyc = 0;
    while (idx < d && cyc < 4000) begin
      din = dw_q[idx];
      din_vld = ($urandom_range(0, 99) < vld_pct);
      drive_re((bp_cycles > 0 && cyc < bp_cycles) ? 2 : re_mode);
      start = junk && (cyc == 3);
      @(negedge hclk);
      if (din_vld && din_re) idx++;
      if (bp_cycles > 0 && cyc == bp_cycles - 1) begin
        check("bp_accepted", idx, bp_k);
        check("bp_din_re", din_re, 0);
      end
      @(posedge hclk); #1;
      cyc++;
    end
    if (idx < d) check("din_timeout", idx, d);
    din_vld = 1'b0; start = 1'b0;
    got = 0; cyc = 0;
    while (!got && cyc < 4000) begin
      drive_re(re_mode);
      @(negedge hclk);
      if (done) got = 1;
      @(posedge hclk); #1;
      cyc++;
    end
    check("done_seen", got, 1);
    check("leftover", exp_data.size(), 0);
    dout_re = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepted, cyc;
    // reset state
    #12;
    check("rst_din_re", din_re, 0);
    check("rst_dout", dout, 0);
    check("rst_wstb", dout_wstb, 0);
    check("rst_dout_vld", dout_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge hclk); hrst_n = 1'b1;

    // aligned
    dw_q = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006};
    model_fill(0, 7);
    check("lit_al_n", exp_data.size(), 2);
    check("lit_al_d0", exp_data[0], 64'h0003000200010000);
    check("lit_al_s0", exp_stb[0], 8'hFF);
    check("lit_al_d1", exp_data[1], 64'h0007000600050004);
    run_xfer(0, 7, 1, 100, 0, 0, 0);

    // offset, odd count
    dw_q = '{32'hBBBBAAAA, 32'hDDDDCCCC};
    model_fill(1, 2);
    check("lit_off_n", exp_data.size(), 1);
    check("lit_off_d", exp_data[0], 64'hCCCCBBBBAAAA0000);
    check("lit_off_s", exp_stb[0], 8'hFC);
    run_xfer(1, 2, 1, 100, 0, 0, 0);

    // straddle
    dw_q = '{32'h22221111};
    model_fill(3, 1);
    check("lit_st_d0", exp_data[0], 64'h1111000000000000);
    check("lit_st_s0", exp_stb[0], 8'hC0);
    check("lit_st_d1", exp_data[1], 64'h0000000000002222);
    check("lit_st_s1", exp_stb[1], 8'h03);
    run_xfer(3, 1, 0, 100, 0, 0, 0);

    // single word
    dw_q = '{32'h5555ABCD};
    model_fill(0, 0);
    check("lit_one_s", exp_stb[0], 8'h03);
    check("lit_one_d", exp_data[0], 64'h000000000000ABCD);
    run_xfer(0, 0, 1, 100, 0, 0, 0);

    // backpressure: 14 dwords fit (7 QWORDs) before din_re drops
    load_dwords(39);
    model_fill(0, 39);
    check("lit_bp_q", exp_data.size(), 10);
    run_xfer(0, 39, 1, 100, 60, 14, 0);

    // reset mid-transfer
    mon_en = 0;
    load_dwords(15);
    @(posedge hclk); #1;
    start = 1'b1; wcnt_in = WB'(15); woffs_in = 2'd0;
    @(posedge hclk); #1;
    start = 1'b0;
    accepted = 0; cyc = 0;
    while (accepted < 3 && cyc < 100) begin
      din = dw_q[accepted]; din_vld = 1'b1;
      @(negedge hclk);
      if (din_re) accepted++;
      @(posedge hclk); #1;
      cyc++;
    end
    din_vld = 1'b0;
    @(posedge hclk); #1;
    check("mid_busy", busy, 1);
    check("mid_vld", dout_vld, 1);
    #2 hrst_n = 1'b0;
    #1;
    check("arst_din_re", din_re, 0);
    check("arst_dout", dout, 0);
    check("arst_wstb", dout_wstb, 0);
    check("arst_vld", dout_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (2) @(posedge hclk);
    @(negedge hclk); hrst_n = 1'b1;
    load_dwords(3);
    model_fill(0, 3);
    check("lit_rr_s", exp_stb[0], 8'hFF);
    check("lit_rr_d", exp_data[0], {dw_q[1], dw_q[0]});
    run_xfer(0, 3, 0, 100, 0, 0, 0);

`ifdef AHCI_DMA_WR_PACK_ABORT_EN
    mon_en = 0;
    load_dwords(31);
    @(posedge hclk); #1;
    start = 1'b1; wcnt_in = WB'(31); woffs_in = 2'd0; dout_re = 1'b0;
    @(posedge hclk); #1;
    start = 1'b0;
    accepted = 0; cyc = 0;
    while (accepted < 2 && cyc < 100) begin
      din = dw_q[accepted]; din_vld = 1'b1;
      @(negedge hclk);
      if (din_re) accepted++;
      @(posedge hclk); #1;
      cyc++;
    end
    abort = 1'b1; dout_re = 1'b1; start = 1'b1;
    @(posedge hclk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge hclk);
    check("ab_vld", dout_vld, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 1);
    check("ab_din_re", din_re, 0);
    @(negedge hclk);
    check("ab_done_1", done, 0);
    check("ab_din_re_1", din_re, 0);
    din_vld = 1'b0; dout_re = 1'b0;
    @(posedge hclk); #1;
`endif

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      int wo, wc;
      wo = $urandom_range(0, 3);
      wc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 160) : $urandom_range(0, 45);
      load_dwords(wc);
      run_xfer(wo, wc, $urandom_range(0, 1), $urandom_range(30, 100), 0, 0,
               1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge hclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
